// File: rtl/plot_framebuffer_writer_if.sv
// Plot request stream and framebuffer write port shared by the plot writer and its environment.
// The slave side is the writer; the master side is whoever issues plots and owns the memory.
interface plot_framebuffer_writer_if;
    logic        plot;
    logic [8:0]  X;
    logic [7:0]  Y;
    logic [2:0]  color;
    logic        clear_req;
    logic [2:0]  clear_color;
    logic        full;
    logic        busy;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_ready;
    logic        clear_done;
    logic [7:0]  dropped;

    modport master (
        output plot, X, Y, color, clear_req, clear_color, mem_ready,
        input  full, busy, mem_we, mem_addr, mem_data, clear_done, dropped
    );

    modport slave (
        input  plot, X, Y, color, clear_req, clear_color, mem_ready,
        output full, busy, mem_we, mem_addr, mem_data, clear_done, dropped
    );
endinterface

// File: rtl/plot_framebuffer_writer.sv
// Buffers pixel plot requests in a small FIFO and turns them into framebuffer writes,
// with an in-order clear-screen sweep that fills every word with one colour.
module plot_framebuffer_writer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input logic clock,
    input logic reset,
    plot_framebuffer_writer_if.slave bus
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [16:0] LAST_ADDR  = 17'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t         state, state_next;
    logic [19:0]    fifo_mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    count, count_next;
    logic [AW:0]    drain_left, drain_left_next;
    logic [16:0]    clear_addr, clear_addr_next;
    logic [2:0]     fill_color, fill_color_next;
    logic           clear_done_q;
    logic [7:0]     dropped_q;

    logic           in_range, fifo_full, fifo_empty;
    logic           push, pop, fifo_we, last_accept;
    logic [16:0]    push_addr;

    assign in_range   = (int'(bus.X) < SCREEN_W) && (int'(bus.Y) < SCREEN_H);
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push       = bus.plot && in_range && !fifo_full;
    assign push_addr  = 17'(int'(bus.Y) * SCREEN_W + int'(bus.X));

    // Only entries queued before the clear request may drain ahead of the sweep.
    assign fifo_we    = (state == IDLE  && !fifo_empty) ||
                        (state == DRAIN && drain_left != '0);
    assign pop        = fifo_we && bus.mem_ready;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_next      = state;
        drain_left_next = drain_left;
        clear_addr_next = clear_addr;
        fill_color_next = fill_color;
        last_accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    fill_color_next = bus.clear_color;
                    drain_left_next = count_next;
                    state_next      = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_left == '0) begin
                    clear_addr_next = '0;
                    state_next      = CLEAR;
                end else if (pop) begin
                    drain_left_next = drain_left - 1'b1;
                end
            end
            CLEAR: begin
                if (bus.mem_ready) begin
                    if (clear_addr == LAST_ADDR) begin
                        last_accept = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        clear_addr_next = clear_addr + 17'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            drain_left   <= '0;
            clear_addr   <= '0;
            fill_color   <= '0;
            clear_done_q <= 1'b0;
            dropped_q    <= '0;
        end else begin
            state        <= state_next;
            drain_left   <= drain_left_next;
            clear_addr   <= clear_addr_next;
            fill_color   <= fill_color_next;
            count        <= count_next;
            clear_done_q <= last_accept;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.plot && in_range && fifo_full && dropped_q != 8'hFF)
                dropped_q <= dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {push_addr, bus.color};
    end

    // Address and data read as zero whenever no write is being offered.
    assign bus.mem_we     = fifo_we || (state == CLEAR);
    assign bus.mem_addr   = (state == CLEAR) ? clear_addr :
                            (fifo_we ? fifo_mem[rd_ptr][19:3] : 17'd0);
    assign bus.mem_data   = (state == CLEAR) ? fill_color :
                            (fifo_we ? fifo_mem[rd_ptr][2:0] : 3'd0);
    assign bus.full       = fifo_full;
    assign bus.busy       = !fifo_empty || (state != IDLE);
    assign bus.clear_done = clear_done_q;
    assign bus.dropped    = dropped_q;
endmodule

// File: tb/tb_plot_framebuffer_writer.sv
// Self-checking bench for plot_framebuffer_writer: table vectors, hand-written
// corner sequences and a randomized phase checked against a queue-based model.
module tb_plot_framebuffer_writer;
    localparam int DEPTH  = 8;
    localparam int W      = 320;
    localparam int H      = 240;
    localparam int PIXELS = W * H;

    logic clock = 1'b0;
    logic reset = 1'b1;

    plot_framebuffer_writer_if bus();

    plot_framebuffer_writer #(.DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [19:0] acc_q[$];
    logic [19:0] model_q[$];
    int          model_dropped = 0;
    bit          model_on = 1'b0;

    typedef struct {
        logic plot;
        int   x, y, c;
        logic rdy;
        logic exp_we;
        int   exp_addr, exp_data;
        logic exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference behaviour: a queue of {address, colour} in request order.
    task automatic model_cycle(input logic p, input int x, input int y, input int c, input logic rdy);
        int size;
        size = model_q.size();
        checkOutput("rand_mem_we",  int'(bus.mem_we),  int'(size != 0));
        checkOutput("rand_full",    int'(bus.full),    int'(size == DEPTH));
        checkOutput("rand_busy",    int'(bus.busy),    int'(size != 0));
        checkOutput("rand_dropped", int'(bus.dropped), model_dropped);
        if (size != 0)
            checkOutput("rand_head", int'({bus.mem_addr, bus.mem_data}), int'(model_q[0]));
        if (rdy && size != 0) void'(model_q.pop_front());
        if (p && x < W && y < H) begin
            if (size < DEPTH) model_q.push_back({17'(y * W + x), 3'(c)});
            else if (model_dropped < 255) model_dropped++;
        end
    endtask

    task automatic applyStimulus(input logic p, input int x, input int y, input int c,
                                 input logic cr, input int cc, input logic rdy);
        bus.plot        = p;
        bus.X           = 9'(x);
        bus.Y           = 8'(y);
        bus.color       = 3'(c);
        bus.clear_req   = cr;
        bus.clear_color = 3'(cc);
        bus.mem_ready   = rdy;
        if (bus.mem_we && rdy) acc_q.push_back({bus.mem_addr, bus.mem_data});
        if (model_on) model_cycle(p, x, y, c, rdy);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        bus.plot = 1'b0; bus.X = '0; bus.Y = '0; bus.color = '0;
        bus.clear_req = 1'b0; bus.clear_color = '0; bus.mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        acc_q.delete();
        model_q.delete();
        model_dropped = 0;
    endtask

    initial begin
        int errs, done_pulses, done_at, iter;

        vecs[0] = '{1'b1,   5,   2, 3, 1'b1, 1'b1,   645, 3, 1'b1};
        vecs[1] = '{1'b0,   0,   0, 0, 1'b1, 1'b0,     0, 0, 1'b0};
        vecs[2] = '{1'b1, 320,  10, 5, 1'b1, 1'b0,     0, 0, 1'b0};
        vecs[3] = '{1'b1,   0, 240, 5, 1'b1, 1'b0,     0, 0, 1'b0};
        vecs[4] = '{1'b1, 319, 239, 7, 1'b1, 1'b1, 76799, 7, 1'b1};
        vecs[5] = '{1'b1,   0,   0, 1, 1'b1, 1'b1,     0, 1, 1'b1};
        vecs[6] = '{1'b0,   0,   0, 0, 1'b0, 1'b1,     0, 1, 1'b1};
        vecs[7] = '{1'b0,   0,   0, 0, 1'b1, 1'b0,     0, 0, 1'b0};

        apply_reset();
        checkOutput("reset_mem_we",     int'(bus.mem_we),     0);
        checkOutput("reset_mem_addr",   int'(bus.mem_addr),   0);
        checkOutput("reset_mem_data",   int'(bus.mem_data),   0);
        checkOutput("reset_full",       int'(bus.full),       0);
        checkOutput("reset_busy",       int'(bus.busy),       0);
        checkOutput("reset_clear_done", int'(bus.clear_done), 0);
        checkOutput("reset_dropped",    int'(bus.dropped),    0);

        // Single plots, out-of-range rejects, back-to-back throughput and a one-cycle stall.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, 0, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_mem_we", i), int'(bus.mem_we), int'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                checkOutput($sformatf("vec%0d_mem_addr", i), int'(bus.mem_addr), vecs[i].exp_addr);
                checkOutput($sformatf("vec%0d_mem_data", i), int'(bus.mem_data), vecs[i].exp_data);
            end
            checkOutput($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_dropped", i), int'(bus.dropped), 0);
        end

        // Fill under stall, two drops, then a push rejected while popping from full.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, i, 1, i % 8, 1'b0, 0, 1'b0);
            checkOutput($sformatf("fill%0d_full", i), int'(bus.full), int'(i >= 7));
            checkOutput($sformatf("fill%0d_hold_addr", i), int'(bus.mem_addr), 320);
            checkOutput($sformatf("fill%0d_hold_we", i), int'(bus.mem_we), 1);
        end
        checkOutput("fill_dropped", int'(bus.dropped), 2);
        applyStimulus(1'b1, 50, 1, 5, 1'b0, 0, 1'b1);
        checkOutput("pop_full_falls", int'(bus.full), 0);
        checkOutput("pop_push_rejected", int'(bus.dropped), 3);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
        checkOutput("drain_count", acc_q.size(), 8);
        for (int i = 0; i < 8 && i < acc_q.size(); i++)
            checkOutput($sformatf("drain%0d_write", i), int'(acc_q[i]), int'({17'(320 + i), 3'(i % 8)}));
        checkOutput("drain_busy", int'(bus.busy), 0);

        // Drop counter saturation.
        apply_reset();
        for (int i = 0; i < 308; i++) begin
            applyStimulus(1'b1, i % W, 3, 2, 1'b0, 0, 1'b0);
            if (i == 261) checkOutput("sat_254", int'(bus.dropped), 254);
            if (i == 262) checkOutput("sat_255", int'(bus.dropped), 255);
            if (i == 263) checkOutput("sat_hold", int'(bus.dropped), 255);
        end
        checkOutput("sat_final", int'(bus.dropped), 255);
        checkOutput("sat_full", int'(bus.full), 1);

        // Clear ordered between earlier and later plots; a stray clear_req mid-sweep is ignored.
        apply_reset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 10 + i, 20, i + 1, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 6, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 100 + i, 50, 4 + i, 1'b0, 0, 1'b0);
        checkOutput("clr_stall_addr", int'(bus.mem_addr), 6410);
        checkOutput("clr_stall_busy", int'(bus.busy), 1);
        done_pulses = 0;
        done_at = -1;
        iter = 0;
        while (acc_q.size() < PIXELS + 5 && iter < PIXELS + 100) begin
            if (bus.clear_done) begin done_pulses++; done_at = acc_q.size(); end
            applyStimulus(1'b0, 0, 0, 0, iter == 500, 2, 1'b1);
            iter++;
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.clear_done) begin done_pulses++; done_at = acc_q.size(); end
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
        end
        checkOutput("clr_total_writes", acc_q.size(), PIXELS + 5);
        checkOutput("clr_done_pulses", done_pulses, 1);
        checkOutput("clr_done_timing", done_at, PIXELS + 3);
        if (acc_q.size() >= PIXELS + 5) begin
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("clr_pre%0d", i), int'(acc_q[i]), int'({17'(6410 + i), 3'(i + 1)}));
            errs = 0;
            for (int i = 0; i < PIXELS; i++)
                if (acc_q[3 + i] != {17'(i), 3'd6}) errs++;
            checkOutput("clr_sweep_errors", errs, 0);
            for (int i = 0; i < 2; i++)
                checkOutput($sformatf("clr_post%0d", i), int'(acc_q[PIXELS + 3 + i]),
                            int'({17'(16100 + i), 3'(4 + i)}));
        end
        checkOutput("clr_end_busy", int'(bus.busy), 0);
        checkOutput("clr_end_mem_we", int'(bus.mem_we), 0);

        // Clear from empty idle, then reset in the middle of the sweep.
        apply_reset();
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 5, 1'b1);
        checkOutput("rst_drain_we", int'(bus.mem_we), 0);
        checkOutput("rst_drain_busy", int'(bus.busy), 1);
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
        checkOutput("rst_first_we", int'(bus.mem_we), 1);
        checkOutput("rst_first_addr", int'(bus.mem_addr), 0);
        checkOutput("rst_first_data", int'(bus.mem_data), 5);
        iter = 0;
        while (bus.mem_addr != 17'd1000 && iter < 1100) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
            iter++;
        end
        checkOutput("rst_reached_1000", int'(bus.mem_addr), 1000);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rst_mid_mem_we", int'(bus.mem_we), 0);
        checkOutput("rst_mid_busy", int'(bus.busy), 0);
        checkOutput("rst_mid_addr", int'(bus.mem_addr), 0);
        checkOutput("rst_mid_done", int'(bus.clear_done), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
            checkOutput($sformatf("rst_after%0d_done", i), int'(bus.clear_done), 0);
            checkOutput($sformatf("rst_after%0d_we", i), int'(bus.mem_we), 0);
        end

        // Randomized plots and memory back-pressure against the queue model.
        apply_reset();
        model_on = 1'b1;
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 335), $urandom_range(0, 250),
                          $urandom_range(0, 7), 1'b0, 0, $urandom_range(0, 9) < 4);
        model_on = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
